// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per enabled cycle; signed ops work on magnitudes and
// fix up signs in a single FINISH cycle.
//
// Handshake: start is taken only on an enabled edge while the FSM is IDLE
// and flush is low. Once taken, busy stays high until the result is written.
// done pulses for one enabled cycle with hi/lo already updated.
// A start seen while busy is dropped, not queued.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       fsm_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Latched operation context.
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;    // product upper half / partial remainder / raw dividend on dz
  logic [WIDTH-1:0] acc_lo;    // multiplier then product lower half / dividend then quotient
  logic [WIDTH-1:0] oper_b;    // multiplicand or divisor magnitude
  logic             is_mul;
  logic             is_signed;
  logic             neg_a;
  logic             neg_b;
  logic             zero_div;

  // Request decode.
  logic             req_mul;
  logic             req_div;
  logic             req_signed;
  logic             b_zero;
  logic             accept;
  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Iteration datapath.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  // Result formation.
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Decode the incoming request and take operand magnitudes.
  always_comb begin
    req_mul    = (op == OP_MULT) || (op == OP_MULTU);
    req_div    = (op == OP_DIV)  || (op == OP_DIVU);
    req_signed = (op == OP_MULT) || (op == OP_DIV);
    b_zero     = (b == '0);
    accept     = (state == IDLE) && start && !flush;
    a_neg_in   = req_signed && a[WIDTH-1];
    b_neg_in   = req_signed && b[WIDTH-1];
    a_mag      = a_neg_in ? -a : a;
    b_mag      = b_neg_in ? -b : b;
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, oper_b} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, oper_b});
    // Only used when div_ge holds, so the true difference fits in WIDTH bits.
    div_sub   = div_shift[WIDTH-1:0] - oper_b;
  end

  // Sign correction and hi/lo selection for the FINISH cycle.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (is_signed && (neg_a ^ neg_b)) ? -prod : prod;
    quo_fix  = (is_signed && (neg_a ^ neg_b)) ? -acc_lo : acc_lo;
    rem_fix  = (is_signed && neg_a) ? -acc_hi : acc_hi;
    if (zero_div) begin
      hi_res = acc_hi;
      lo_res = '1;
    end else if (is_mul) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else begin
      hi_res = rem_fix;
      lo_res = quo_fix;
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && req_mul) begin
          state_next = CALC;
        end else if (accept && req_div) begin
          state_next = b_zero ? FINISH : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(WIDTH - 1)) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // State register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_next;
    end
  end

  // Operand capture, iteration, result write-back and done/dz pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      oper_b    <= '0;
      is_mul    <= 1'b0;
      is_signed <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      zero_div  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      dz        <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      dz   <= 1'b0;
      if (!flush) begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (op == OP_MTHI) begin
                hi <= a;
              end else if (op == OP_MTLO) begin
                lo <= a;
              end else if (req_mul || req_div) begin
                cnt       <= '0;
                is_mul    <= req_mul;
                is_signed <= req_signed;
                neg_a     <= a_neg_in;
                neg_b     <= b_neg_in;
                oper_b    <= b_mag;
                acc_lo    <= a_mag;
                zero_div  <= req_div && b_zero;
                // On a zero divisor the raw dividend is parked for hi.
                acc_hi    <= (req_div && b_zero) ? a : '0;
              end
            end
          end
          CALC: begin
            cnt <= cnt + CNT_W'(1);
            if (is_mul) begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end else begin
              acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end
          end
          FINISH: begin
            hi   <= hi_res;
            lo   <= lo_res;
            done <= 1'b1;
            dz   <= zero_div;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic model.
module tb_mul_div_unit;

  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .dz        (dz),
    .hi        (hi),
    .lo        (lo),
    .fsm_state (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural operands.
  task automatic model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic ez);
    longint       sa;
    longint       sb;
    longint       q;
    longint       r;
    logic [63:0]  t;
    logic [63:0]  u;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      OP_MULT: begin
        t = sa * sb;
        eh = t[63:32];
        el = t[31:0];
      end
      OP_MULTU: begin
        t = {32'b0, av} * {32'b0, bv};
        eh = t[63:32];
        el = t[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (bv == '0) begin
          eh = av;
          el = '1;
          ez = 1'b1;
        end else if (o == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          t = q;
          u = r;
          el = t[31:0];
          eh = u[31:0];
        end else begin
          el = av / bv;
          eh = av % bv;
        end
      end
      default: ;
    endcase
  endtask

  // Issue a multiply/divide and follow it to done. Returns in the done cycle,
  // so a following op's start lands while done is high.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int stall_at, input int stall_len, input string tag);
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         ez;
    int           n;
    int           busy_n;
    int           lat;
    model(o, av, bv, eh, el, ez);
    op = o; a = av; b = bv; start = 1'b1;
    cyc();
    start = 1'b0;
    chk({tag, "_done_low_at_accept"}, done, 0);
    chk({tag, "_dz_low_at_accept"}, dz, 0);
    n = 0;
    busy_n = 0;
    while (!done && n < 200) begin
      if (stall_len > 0 && n == stall_at) en = 1'b0;
      if (stall_len > 0 && n == stall_at + stall_len) en = 1'b1;
      if (busy) busy_n++;
      cyc();
      n++;
    end
    en = 1'b1;
    lat = (ez ? 1 : W + 1) + stall_len;
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_cycles"}, busy_n, lat);
    chk({tag, "_busy_low_at_done"}, busy, 0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_dz"}, dz, ez);
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic mt_op(input logic [2:0] o, input logic [W-1:0] av, input string tag);
    op = o; a = av; start = 1'b1;
    cyc();
    start = 1'b0;
    if (o == OP_MTHI) exp_hi = av;
    else exp_lo = av;
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic no_done_for(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      cyc();
      if (done) seen++;
    end
    chk({tag, "_no_done"}, seen, 0);
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset
    reset = 1'b1; en = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dz", dz, 0);

    // Directed arithmetic corners, issued back to back
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
    run_op(OP_MULT, -32'sd3, 32'sd5, 0, 0, "mult_neg");
    run_op(OP_DIV, -32'sd7, 32'sd2, 0, 0, "div_neg");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
    run_op(OP_DIVU, 32'd7, 32'd0, 0, 0, "divu_zero");
    run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, 0, 0, "div_zero");
    run_op(OP_DIV, 32'd100, -32'sd7, 0, 0, "div_negb");
    cyc();
    chk("dz_clears", dz, 0);

    // Ignored opcode and start with en low
    op = 3'b110; a = 32'h5555_5555; start = 1'b1;
    cyc();
    op = 3'b111;
    cyc();
    start = 1'b0;
    chk("op_ignored_busy", busy, 0);
    chk("op_ignored_hi", hi, exp_hi);
    chk("op_ignored_lo", lo, exp_lo);
    en = 1'b0; op = OP_MTHI; a = 32'h0BAD_0BAD; start = 1'b1;
    cyc();
    start = 1'b0; en = 1'b1;
    chk("en_low_start_hi", hi, exp_hi);

    // Flush priority over a same-cycle start
    op = OP_MTLO; a = 32'hAAAA_AAAA; start = 1'b1; flush = 1'b1;
    cyc();
    op = OP_MULT;
    cyc();
    start = 1'b0; flush = 1'b0;
    chk("flush_prio_lo", lo, exp_lo);
    chk("flush_prio_busy", busy, 0);

    // MTHI, then a multiply flushed mid-CALC with an ignored start while busy
    mt_op(OP_MTHI, 32'h0000_1234, "mthi");
    op = OP_MULTU; a = $urandom; b = $urandom; start = 1'b1;
    cyc();
    op = OP_MTLO; a = 32'hDEAD_BEEF;
    repeat (10) cyc();
    start = 1'b0;
    chk("busy_start_ignored_lo", lo, exp_lo);
    chk("busy_before_flush", busy, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi", hi, 32'h0000_1234);
    no_done_for(40, "flush");
    chk("flush_lo_after", lo, exp_lo);

    // Enable stall mid-CALC, then en low across the done pulse
    run_op(OP_MULT, $urandom, $urandom, 10, 5, "stall_mult");
    en = 1'b0;
    cyc();
    chk("done_held_1", done, 1);
    cyc();
    chk("done_held_2", done, 1);
    chk("done_held_hi", hi, exp_hi);
    en = 1'b1;
    cyc();
    chk("done_released", done, 0);
    run_op(OP_DIVU, $urandom, 32'($urandom_range(1, 1000)), 3, 4, "stall_divu");

    // Reset mid-CALC
    op = OP_DIV; a = $urandom; b = 32'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (10) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midreset_hi", hi, 0);
    chk("midreset_lo", lo, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_dz", dz, 0);
    exp_hi = '0;
    exp_lo = '0;
    no_done_for(40, "midreset");

    // Random operations
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = '0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if (ro >= OP_MTHI) mt_op(ro, ra, "rand_mt");
      else run_op(ro, ra, rb, 0, 0, "rand_op");
    end
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and hi/lo width; legal range 4..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: global enable; when low, all registers hold.
REQ-005 SHALL have port start, input, 1 bit: request an operation.
REQ-006 SHALL have port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are ignored.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: a is the multiplicand or dividend; b is the multiplier or divisor.
REQ-008 SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port dz, output, 1 bit: the completed divide had a zero divisor; valid while done is high.
REQ-012 SHALL have ports hi and lo, output, WIDTH bits each: the architectural HI and LO registers.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and FINISH; busy SHALL be high exactly when the state is not IDLE.
REQ-014 SHALL accept start only when state is IDLE, en=1, flush=0 and reset=0; start in any other condition SHALL be ignored, with no queuing.
REQ-015 SHALL, on an accepted MTHI or MTLO, load a into hi or lo respectively at that edge, stay in IDLE, and not assert done.
REQ-016 SHALL, on an accepted MULT/MULTU/DIV/DIVU with a nonzero divisor where relevant, latch the operand magnitudes, signs and op, clear the iteration counter, and enter CALC.
REQ-017 SHALL perform one radix-2 shift-add step (multiply) or restoring-subtract step (divide) per enabled cycle in CALC, for exactly WIDTH cycles, then enter FINISH.
REQ-018 SHALL, in FINISH, apply sign correction: product negated if the operand signs differ; quotient negated if signs differ; remainder takes the sign of the dividend. Unsigned ops SHALL skip correction.
REQ-019 SHALL, at the edge leaving FINISH, write hi/lo (multiply: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH product; divide: hi = remainder, lo = quotient), register done=1 for exactly one cycle, and return to IDLE.
REQ-020 SHALL give latency for multiply or nonzero-divisor divide as: start accepted at edge k, done high in the cycle after edge k+WIDTH+1, with busy high for WIDTH+1 cycles.
REQ-021 SHALL, for DIV/DIVU with b=0, skip CALC and go IDLE->FINISH, then set hi=a, lo=all ones, dz=1; done SHALL be high in the cycle after edge k+1.
REQ-022 SHALL, for DIV with a=most-negative and b=-1, produce lo=most-negative (wrapped quotient) and hi=0, with dz=0.
REQ-023 SHALL, on flush=1 at an enabled edge, set state to IDLE with hi/lo unchanged, done=0 and the result discarded; flush SHALL take priority over a same-cycle start.
REQ-024 SHALL accept a new start in the same cycle that done is high, since the state is IDLE then.
REQ-025 SHALL keep dz low except in a done cycle caused by REQ-021.
REQ-026 SHALL, when en=0 in any state, freeze state, counter, hi, lo and done; a done pulse in progress SHALL remain high until the next enabled edge.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, set the state to IDLE and set hi, lo, busy, done, dz and the counter to 0; reset SHALL take priority over en, flush and start.
REQ-028 SHALL, on reset mid-operation, discard the operation and produce no done pulse.

Verification (WIDTH=32)
REQ-029 SHALL cover: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 edges after the accepting edge, hi=0xFFFFFFFE, lo=0x00000001, busy high 33 cycles.
REQ-030 SHALL cover: MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-031 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, dz=0; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 SHALL cover: DIVU a=7, b=0 -> done the cycle after edge k+1, dz=1, hi=7, lo=0xFFFFFFFF.
REQ-033 SHALL cover: MTHI 0x1234 followed by MULTU with flush at CALC cycle 10 -> busy low the next cycle, hi stays 0x1234, no done; start asserted during busy is ignored.
REQ-034 SHALL cover: en low for 5 cycles mid-CALC -> done delayed by exactly 5 cycles with the correct result; reset mid-CALC -> all outputs 0, no done.
